// File: rtl/order_n_pipe.sv
// Two-stage stable N-key sorter with valid/ready flow control.
// Define ORDER_INDEX_OUT_EN to add the out_index port and index registers.
module order_n_pipe #(
   parameter int DSIZE = 64,
   parameter int NUM = 4,
   parameter int ASCEND = 0,
   localparam int IDXW = $clog2(NUM)
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM*DSIZE-1:0]  in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NUM*DSIZE-1:0]  out_data
`ifdef ORDER_INDEX_OUT_EN
   ,
   output logic [NUM*IDXW-1:0]   out_index
`endif
);

   logic v1;
   logic v2;
   logic adv1;
   logic adv2;
   logic [DSIZE-1:0] k1 [NUM];
   logic [NUM-1:0] gt1 [NUM];
   logic [NUM-1:0] gt_d [NUM];
   logic [IDXW-1:0] rank [NUM];
   logic [NUM*DSIZE-1:0] sd;
`ifdef ORDER_INDEX_OUT_EN
   logic [NUM*IDXW-1:0] si;
`endif

   assign adv2 = !v2 || out_ready;
   assign adv1 = !v1 || adv2;
   assign in_ready = adv1;
   assign out_valid = v2;

   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         for (int j = 0; j < NUM; j++) begin
            gt_d[i][j] = in_data[i*DSIZE +: DSIZE] >
                         in_data[j*DSIZE +: DSIZE];
         end
      end
   end

   // Self-compare bits are always 0, so j == i adds nothing to a rank.
   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         rank[i] = '0;
         for (int j = 0; j < NUM; j++) begin
            if (ASCEND != 0)
               rank[i] = rank[i] + IDXW'(gt1[i][j]);
            else
               rank[i] = rank[i] + IDXW'(gt1[j][i]);
            if (j < i && !gt1[i][j] && !gt1[j][i])
               rank[i] = rank[i] + IDXW'(1);
         end
      end
   end

   // Ranks are a permutation, so exactly one key lands in each slot.
   always_comb begin
      sd = '0;
`ifdef ORDER_INDEX_OUT_EN
      si = '0;
`endif
      for (int k = 0; k < NUM; k++) begin
         for (int i = 0; i < NUM; i++) begin
            if (rank[i] == IDXW'(k)) begin
               sd[k*DSIZE +: DSIZE] = sd[k*DSIZE +: DSIZE] | k1[i];
`ifdef ORDER_INDEX_OUT_EN
               si[k*IDXW +: IDXW] = si[k*IDXW +: IDXW] | IDXW'(i);
`endif
            end
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         out_data <= '0;
`ifdef ORDER_INDEX_OUT_EN
         out_index <= '0;
`endif
         for (int i = 0; i < NUM; i++) begin
            k1[i] <= '0;
            gt1[i] <= '0;
         end
      end else begin
         if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
               for (int i = 0; i < NUM; i++) begin
                  k1[i] <= in_data[i*DSIZE +: DSIZE];
                  gt1[i] <= gt_d[i];
               end
            end
         end
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               out_data <= sd;
`ifdef ORDER_INDEX_OUT_EN
               out_index <= si;
`endif
            end
         end
      end
   end

endmodule
